// File: rtl/adc_cic_decim.sv
// adc_cic_decim: third-order CIC decimator, ADC capture to output path.
// Optional CIC_OFFSET_BINARY_EN: accept offset-binary ADC codes.
module adc_cic_decim #(
  parameter int DATA_W = 10,
  parameter int R      = 16,
  parameter int OUT_W  = 16
) (
  input  logic             mclk,
  input  logic             ext_rst,
  input  logic [15:0]      adc,
  input  logic             adc_valid,
  output logic [OUT_W-1:0] dec_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CNT_W = $clog2(R);
  localparam int ACC_W = DATA_W + 3 * CNT_W;
  localparam int EXT_W = ACC_W - DATA_W;

  // Raw sample extraction from the left-justified bus
  logic [DATA_W-1:0] adc_x;

`ifdef CIC_OFFSET_BINARY_EN
  assign adc_x = {~adc[15], adc[14 -: DATA_W-1]};
`else
  assign adc_x = adc[15 -: DATA_W];
`endif

  // Input stage
  logic [DATA_W-1:0] x_q, x_d;
  logic              xv_q, xv_d;

  // Integrators and decimation counter
  logic [ACC_W-1:0] i1_q, i1_d;
  logic [ACC_W-1:0] i2_q, i2_d;
  logic [ACC_W-1:0] i3_q, i3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dv_q, dv_d;

  // Comb stages
  logic [ACC_W-1:0] c1_q, c1_d;
  logic [ACC_W-1:0] d1_q, d1_d;
  logic             c1v_q, c1v_d;
  logic [ACC_W-1:0] c2_q, c2_d;
  logic [ACC_W-1:0] d2_q, d2_d;
  logic             c2v_q, c2v_d;
  logic [ACC_W-1:0] d3_q, d3_d;
  logic [ACC_W-1:0] c3;

  // Output holding register
  logic [OUT_W-1:0] out_q, out_d;
  logic             ov_q, ov_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0]       x_ext;
  logic [ACC_W+OUT_W-1:0] c3_wide;
  logic [OUT_W-1:0]       c3_t;
  logic                   unused_bits;

  assign x_ext = {{EXT_W{x_q[DATA_W-1]}}, x_q};

  // Zero-padding on the right keeps the top-OUT_W slice legal
  // even when the accumulator is narrower than the output.
  assign c3      = c2_q - d3_q;
  assign c3_wide = {c3, {OUT_W{1'b0}}};
  assign c3_t    = c3_wide[ACC_W+OUT_W-1 -: OUT_W];

  assign unused_bits = ^{adc[15-DATA_W:0], c3_wide[ACC_W-1:0]};

  // Input register next state: capture only qualified samples
  always_comb begin
    x_d  = x_q;
    xv_d = adc_valid;
    if (adc_valid) begin
      x_d = adc_x;
    end
  end

  // Input register state
  always_ff @(posedge mclk or posedge ext_rst) begin
    if (ext_rst) begin
      x_q  <= '0;
      xv_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      xv_q <= xv_d;
    end
  end

  // Integrator cascade next state; wraps modulo 2^ACC_W
  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    dv_d  = 1'b0;
    if (xv_q) begin
      i1_d  = i1_q + x_ext;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + CNT_W'(1);
      dv_d  = (cnt_q == CNT_W'(R - 1));
    end
  end

  // Integrator and counter state
  always_ff @(posedge mclk or posedge ext_rst) begin
    if (ext_rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      i3_q  <= '0;
      cnt_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      i3_q  <= i3_d;
      cnt_q <= cnt_d;
      dv_q  <= dv_d;
    end
  end

  // First and second comb next state; delays move only on decimated samples
  always_comb begin
    c1_d  = c1_q;
    d1_d  = d1_q;
    c1v_d = dv_q;
    c2_d  = c2_q;
    d2_d  = d2_q;
    c2v_d = c1v_q;
    if (dv_q) begin
      c1_d = i3_q - d1_q;
      d1_d = i3_q;
    end
    if (c1v_q) begin
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
    end
  end

  // First and second comb state
  always_ff @(posedge mclk or posedge ext_rst) begin
    if (ext_rst) begin
      c1_q  <= '0;
      d1_q  <= '0;
      c1v_q <= 1'b0;
      c2_q  <= '0;
      d2_q  <= '0;
      c2v_q <= 1'b0;
    end else begin
      c1_q  <= c1_d;
      d1_q  <= d1_d;
      c1v_q <= c1v_d;
      c2_q  <= c2_d;
      d2_q  <= d2_d;
      c2v_q <= c2v_d;
    end
  end

  // Third comb feeds the holding register; a result that finds the
  // register full and unaccepted is dropped and flagged.
  always_comb begin
    d3_d  = d3_q;
    out_d = out_q;
    ov_d  = ov_q;
    ovf_d = ovf_q;
    if (c2v_q) begin
      d3_d = c2_q;
      if (!ov_q || out_ready) begin
        out_d = c3_t;
        ov_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  // Third comb delay and output state
  always_ff @(posedge mclk or posedge ext_rst) begin
    if (ext_rst) begin
      d3_q  <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      d3_q  <= d3_d;
      out_q <= out_d;
      ov_q  <= ov_d;
      ovf_q <= ovf_d;
    end
  end

  assign dec_out   = out_q;
  assign out_valid = ov_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adc_cic_decim.sv
// tb_adc_cic_decim: scoreboard bench for adc_cic_decim.
// Default build (two's complement input), R=16.
module tb_adc_cic_decim;

  logic        mclk;
  logic        ext_rst;
  logic [15:0] adc;
  logic        adc_valid;
  logic [15:0] dec_out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  adc_cic_decim dut (
    .mclk      (mclk),
    .ext_rst   (ext_rst),
    .adc       (adc),
    .adc_valid (adc_valid),
    .dec_out   (dec_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Monitor: every accepted result is popped and compared
  always @(negedge mclk) begin
    if (!ext_rst && out_valid && out_ready) begin
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %0d want none",
                 $signed(dec_out));
      end else begin
        e = exp_q.pop_front();
        if (dec_out !== e) begin
          errors++;
          $display("FAIL result got %0d want %0d",
                   $signed(dec_out), $signed(e));
        end
      end
    end
  end

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    ext_rst   = 1'b1;
    adc_valid = 1'b0;
    adc       = 16'h0000;
    out_ready = 1'b0;
    step();
    step();
    ext_rst = 1'b0;
  endtask

  task automatic push_seq(int a, int b, int s, int n);
    exp_q.push_back(16'(a));
    exp_q.push_back(16'(b));
    for (int i = 2; i < n; i++) exp_q.push_back(16'(s));
  endtask

  task automatic drain(string name);
    adc_valid = 1'b0;
    repeat (12) step();
    chk(name, exp_q.size(), 0);
  endtask

  task automatic run_cont(logic [15:0] w, int n);
    for (int i = 0; i < n; i++) begin
      step();
      adc       = w;
      adc_valid = 1'b1;
      out_ready = 1'b1;
    end
    step();
    adc_valid = 1'b0;
  endtask

  initial begin
    int rise1;
    int rise2;
    logic prev;

    ext_rst   = 1'b1;
    adc       = 16'h0000;
    adc_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_dec_out", int'(dec_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    ext_rst = 1'b0;

    // DC x=1: 560/64=8, 3280/64=51, then 4096/64=64
    do_reset();
    push_seq(8, 51, 64, 6);
    run_cont(16'h0040, 6 * 16);
    drain("dc_pos_queue");
    chk("dc_pos_ovf", int'(ovf), 0);

    // Negative full scale, long enough to wrap the integrators
    do_reset();
    push_seq(-4480, -26240, -32768, 100);
    run_cont(16'h8000, 100 * 16);
    drain("fs_neg_queue");
    chk("fs_neg_ovf", int'(ovf), 0);

    // Positive full scale
    do_reset();
    push_seq(4471, 26188, 32704, 100);
    run_cont(16'h7FC0, 100 * 16);
    drain("fs_pos_queue");
    chk("fs_pos_ovf", int'(ovf), 0);

    // Back-pressure: result 2 lands at cycle 35 with ready low
    do_reset();
    exp_q.push_back(16'd8);
    for (int i = 0; i < 6; i++) exp_q.push_back(16'd64);
    for (int c = 0; c < 140; c++) begin
      step();
      adc       = 16'h0040;
      adc_valid = (c < 128);
      out_ready = (c >= 46);
      if (c == 30) chk("bp_hold_early", int'(dec_out), 8);
      if (c == 45) begin
        chk("bp_hold_late", int'(dec_out), 8);
        chk("bp_valid_held", int'(out_valid), 1);
        chk("bp_ovf_set", int'(ovf), 1);
      end
      if (c == 47) chk("bp_valid_drop", int'(out_valid), 0);
    end
    chk("bp_queue", exp_q.size(), 0);
    chk("bp_ovf_sticky", int'(ovf), 1);

    // Accept and load in the same cycle
    do_reset();
    push_seq(8, 51, 64, 6);
    for (int c = 0; c < 108; c++) begin
      step();
      adc       = 16'h0040;
      adc_valid = (c < 96);
      out_ready = (c == 35) || (c >= 37);
      if (c == 35) chk("sim_old_value", int'(dec_out), 8);
      if (c == 36) begin
        chk("sim_valid_stays", int'(out_valid), 1);
        chk("sim_new_value", int'(dec_out), 51);
      end
    end
    chk("sim_queue", exp_q.size(), 0);
    chk("sim_ovf", int'(ovf), 0);

    // Gapped input, one valid in three; 16th valid at cycle 45
    do_reset();
    push_seq(8, 51, 64, 4);
    rise1 = -1;
    rise2 = -1;
    prev  = 1'b0;
    for (int c = 0; c < 204; c++) begin
      step();
      if (out_valid && !prev) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev      = out_valid;
      adc       = 16'h0040;
      adc_valid = (c % 3 == 0) && (c < 192);
      out_ready = 1'b1;
    end
    chk("gap_latency", rise1 - 45, 5);
    chk("gap_period", rise2 - rise1, 48);
    chk("gap_queue", exp_q.size(), 0);

    // Reset mid-block with a held result and ovf set
    do_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      adc       = 16'h0040;
      adc_valid = 1'b1;
      out_ready = 1'b0;
    end
    step();
    adc_valid = 1'b0;
    chk("mid_pre_ovf", int'(ovf), 1);
    chk("mid_pre_valid", int'(out_valid), 1);
    #2;
    ext_rst = 1'b1;
    #1;
    chk("mid_rst_dec_out", int'(dec_out), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    step();
    step();
    ext_rst = 1'b0;
    push_seq(8, 51, 64, 3);
    rise1 = -1;
    prev  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (out_valid && !prev && rise1 < 0) rise1 = c;
      prev      = out_valid;
      adc       = 16'h0040;
      adc_valid = (c < 48);
      out_ready = 1'b1;
    end
    chk("mid_first_latency", rise1, 20);
    chk("mid_queue", exp_q.size(), 0);
    chk("mid_ovf", int'(ovf), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
